// File: rtl/move_pkg.sv
// Shared types for the piece-movement permit path: directions, controller states,
// the fixed direction priority and small helpers.
package move_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    SETTLE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  typedef struct packed {
    logic hit;
    dir_t dir;
  } dir_sel_t;

  // Highest priority first.
  localparam dir_t DIR_PRIO [4] = '{DIR_DOWN, DIR_LEFT, DIR_RIGHT, DIR_UP};

  function automatic dir_sel_t selectDir(input logic [3:0] req);
    dir_sel_t s;
    s.hit = 1'b0;
    s.dir = DIR_UP;
    for (int i = 0; i < 4; i++) begin
      if (!s.hit && req[DIR_PRIO[i]]) begin
        s.hit = 1'b1;
        s.dir = DIR_PRIO[i];
      end
    end
    return s;
  endfunction

  function automatic int maxOf3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/permit_reduce.sv
// One direction's permit: OR of all participating collision sources, registered.
module permit_reduce #(
  parameter int NUM_SRC = 2,
  parameter int CELLS   = 24
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_SRC-1:0][CELLS-1:0]     blk,
  input  logic [NUM_SRC-1:0]                srcMask,
  output logic                              permit
);

  logic [NUM_SRC-1:0] srcHit;

  always_comb begin
    srcHit = '0;
    for (int s = 0; s < NUM_SRC; s++) srcHit[s] = srcMask[s] & (|blk[s]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) permit <= 1'b0;
    else     permit <= ~|srcHit;
  end

endmodule

// File: rtl/move_permit_ctrl.sv
// Turns held direction buttons into single move requests gated by registered
// per-direction permits, with a post-move settle window and auto-repeat.
module move_permit_ctrl
  import move_pkg::*;
#(
  parameter int NUM_SRC      = 2,
  parameter int ROWS         = 4,
  parameter int COLS         = 6,
  parameter int SETTLE_CYC   = 2,
  parameter int REPEAT_DELAY = 8,
  parameter int REPEAT_RATE  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [3:0]                   dir_req,
  input  logic [NUM_SRC*ROWS*COLS-1:0] blk_up,
  input  logic [NUM_SRC*ROWS*COLS-1:0] blk_down,
  input  logic [NUM_SRC*ROWS*COLS-1:0] blk_left,
  input  logic [NUM_SRC*ROWS*COLS-1:0] blk_right,
  input  logic [NUM_SRC-1:0]           src_mask,
  output logic [3:0]                   enable_o,
  output logic                         move_valid,
  output logic [1:0]                   move_dir,
  input  logic                         move_ack,
  output logic                         deny_pulse
);

  localparam int CELLS = ROWS * COLS;
  localparam int CW    = $clog2(maxOf3(SETTLE_CYC, REPEAT_DELAY, REPEAT_RATE) + 1);

  logic [3:0][NUM_SRC*CELLS-1:0] blkDir;
  assign blkDir = {blk_right, blk_left, blk_down, blk_up};

  for (genvar d = 0; d < 4; d++) begin : gRed
    permit_reduce #(.NUM_SRC(NUM_SRC), .CELLS(CELLS)) uRed (
      .clk,
      .rst,
      .blk     (blkDir[d]),
      .srcMask (src_mask),
      .permit  (enable_o[d])
    );
  end

  state_t         state, stateNxt;
  dir_t           dirQ, dirNxt;
  logic           firstRep, firstRepNxt;
  logic [CW-1:0]  settleCnt, settleNxt;
  logic [CW-1:0]  repTmr, repNxt;
  logic           deny;
  dir_sel_t       sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      dirQ      <= DIR_UP;
      firstRep  <= 1'b1;
      settleCnt <= '0;
      repTmr    <= '0;
    end else begin
      state     <= stateNxt;
      dirQ      <= dirNxt;
      firstRep  <= firstRepNxt;
      settleCnt <= settleNxt;
      repTmr    <= repNxt;
    end
  end

  // Decisions only ever look at the registered permits, never raw blk_* flags.
  always_comb begin
    stateNxt    = state;
    dirNxt      = dirQ;
    firstRepNxt = firstRep;
    settleNxt   = settleCnt;
    repNxt      = repTmr;
    deny        = 1'b0;
    sel         = selectDir(dir_req);
    case (state)
      IDLE: begin
        if (sel.hit) begin
          dirNxt = sel.dir;
          if (enable_o[sel.dir]) begin
            firstRepNxt = 1'b1;
            stateNxt    = ISSUE;
          end else begin
            deny     = 1'b1;
            repNxt   = CW'(REPEAT_DELAY);
            stateNxt = HOLD;
          end
        end
      end
      ISSUE: begin
        if (move_ack) begin
          settleNxt = CW'(SETTLE_CYC);
          stateNxt  = SETTLE;
        end
      end
      SETTLE: begin
        if (settleCnt <= CW'(1)) begin
          settleNxt = '0;
          if (dir_req[dirQ]) begin
            repNxt   = firstRep ? CW'(REPEAT_DELAY) : CW'(REPEAT_RATE);
            stateNxt = HOLD;
          end else begin
            stateNxt = IDLE;
          end
        end else begin
          settleNxt = settleCnt - CW'(1);
        end
      end
      HOLD: begin
        if (!dir_req[dirQ]) begin
          repNxt   = '0;
          stateNxt = IDLE;
        end else if (repTmr <= CW'(1)) begin
          if (enable_o[dirQ]) begin
            firstRepNxt = 1'b0;
            repNxt      = '0;
            stateNxt    = ISSUE;
          end else begin
            deny   = 1'b1;
            repNxt = CW'(REPEAT_RATE);
          end
        end else begin
          repNxt = repTmr - CW'(1);
        end
      end
      default: stateNxt = IDLE;
    endcase
  end

  always_comb begin
    move_valid = (state == ISSUE);
    move_dir   = dirQ;
    deny_pulse = deny & ~rst;
  end

endmodule

// File: tb/tb_move_permit_ctrl.sv
// Directed bench for move_permit_ctrl: a timestamp-based behavioural model checks
// every cycle, and scripted scenarios pin literal expectations.
module tb_move_permit_ctrl;

  localparam int NUM_SRC = 2, ROWS = 4, COLS = 6;
  localparam int CELLS = ROWS * COLS;
  localparam int W = NUM_SRC * CELLS;
  localparam int SETTLE = 2, DELAY = 8, RATE = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    dir_req;
  logic [W-1:0]  blk [4];
  logic [1:0]    src_mask;
  logic [3:0]    enable_o;
  logic          move_valid;
  logic [1:0]    move_dir;
  logic          move_ack;
  logic          deny_pulse;
  logic          autoAck;

  int checks = 0;
  int failures = 0;
  int grants[$];

  move_permit_ctrl #(
    .NUM_SRC(NUM_SRC), .ROWS(ROWS), .COLS(COLS),
    .SETTLE_CYC(SETTLE), .REPEAT_DELAY(DELAY), .REPEAT_RATE(RATE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .dir_req    (dir_req),
    .blk_up     (blk[0]),
    .blk_down   (blk[1]),
    .blk_left   (blk[2]),
    .blk_right  (blk[3]),
    .src_mask   (src_mask),
    .enable_o   (enable_o),
    .move_valid (move_valid),
    .move_dir   (move_dir),
    .move_ack   (move_ack),
    .deny_pulse (deny_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (absolute-cycle deadlines) ----------------
  typedef enum int {M_IDLE, M_PEND, M_SET, M_REP} mmode_e;
  mmode_e      mMode = M_IDLE;
  logic [3:0]  mEn = '0;
  int          mDir = 0;
  bit          mFirst = 1'b1;
  int          mDecide = 0, mDue = 0, cyc = 0;
  int          prio [4] = '{1, 2, 3, 0};  // down, left, right, up

  always @(negedge clk) begin
    logic        expDeny;
    logic [3:0]  nEn;
    bit          found, blocked;
    int          d;
    expDeny = 1'b0;
    if (rst) begin
      mMode = M_IDLE; mDir = 0; mEn = '0; mFirst = 1'b1;
    end
    chk("enable_o", 32'(enable_o), 32'(mEn));
    chk("move_valid", 32'(move_valid), 32'(mMode == M_PEND));
    chk("move_dir", 32'(move_dir), 32'(mDir));
    if (!rst) begin
      case (mMode)
        M_IDLE: begin
          found = 1'b0; d = 0;
          for (int i = 0; i < 4; i++)
            if (!found && dir_req[prio[i]]) begin found = 1'b1; d = prio[i]; end
          if (found) begin
            mDir = d;
            if (mEn[d]) begin mFirst = 1'b1; mMode = M_PEND; end
            else begin expDeny = 1'b1; mDue = cyc + DELAY; mMode = M_REP; end
          end
        end
        M_PEND: if (move_ack) begin mDecide = cyc + SETTLE; mMode = M_SET; end
        M_SET: if (cyc == mDecide) begin
          if (dir_req[mDir]) begin mDue = cyc + (mFirst ? DELAY : RATE); mMode = M_REP; end
          else mMode = M_IDLE;
        end
        M_REP: begin
          if (!dir_req[mDir]) mMode = M_IDLE;
          else if (cyc == mDue) begin
            if (mEn[mDir]) begin mFirst = 1'b0; mMode = M_PEND; end
            else begin expDeny = 1'b1; mDue = cyc + RATE; end
          end
        end
        default: mMode = M_IDLE;
      endcase
    end
    chk("deny_pulse", 32'(deny_pulse), 32'(expDeny));
    if (move_valid && move_ack) grants.push_back(cyc);
    if (!rst) begin
      for (int dd = 0; dd < 4; dd++) begin
        blocked = 1'b0;
        for (int s = 0; s < NUM_SRC; s++)
          for (int c = 0; c < CELLS; c++)
            if (src_mask[s] && blk[dd][s*CELLS+c]) blocked = 1'b1;
        nEn[dd] = !blocked;
      end
      mEn = nEn;
    end
    cyc++;
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk); #1;
      if (autoAck) move_ack = move_valid;
    end
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int base, n;
    rst = 1'b1; dir_req = '0; src_mask = 2'b11; move_ack = 1'b0; autoAck = 1'b0;
    for (int i = 0; i < 4; i++) blk[i] = '0;
    step(3);
    chk("rst_valid", 32'(move_valid), 32'd0);
    chk("rst_enable", 32'(enable_o), 32'd0);

    // Basic grant and ack handshake.
    rst = 1'b0;
    step(1);
    chk("s1_enable_all", 32'(enable_o), 32'hF);
    dir_req = 4'b0010;
    step(1);
    chk("s1_valid", 32'(move_valid), 32'd1);
    chk("s1_dir_down", 32'(move_dir), 32'd1);
    dir_req = '0;
    step(3);
    chk("s1_valid_held", 32'(move_valid), 32'd1);
    move_ack = 1'b1;
    step(1); move_ack = 1'b0;
    chk("s1_valid_drop", 32'(move_valid), 32'd0);
    step(5);
    move_ack = 1'b1;  // stray ack in IDLE
    step(2); move_ack = 1'b0;
    step(2);

    // Wall flag blocks left; masking the wall lets the next repeat through.
    blk[2][24] = 1'b1;
    step(1);
    chk("s2_enable_left_off", 32'(enable_o[2]), 32'd0);
    dir_req = 4'b0100;
    #1 chk("s2_deny_first", 32'(deny_pulse), 32'd1);
    step(1);
    chk("s2_deny_one_cycle", 32'(deny_pulse), 32'd0);
    step(7);
    #1 chk("s2_deny_expiry", 32'(deny_pulse), 32'd1);
    src_mask = 2'b01;
    step(1);
    chk("s2_enable_left_on", 32'(enable_o[2]), 32'd1);
    step(4);
    chk("s2_repeat_valid", 32'(move_valid), 32'd1);
    chk("s2_repeat_dir", 32'(move_dir), 32'd2);
    move_ack = 1'b1;
    step(1);
    move_ack = 1'b0; dir_req = '0; src_mask = 2'b11; blk[2] = '0;
    step(6);

    // Held down with immediate acks: auto-repeat cadence.
    base = grants.size();
    autoAck = 1'b1; dir_req = 4'b0010;
    step(30);
    dir_req = '0;
    step(3);
    n = grants.size() - base;
    chk("s3_grant_count", 32'(n), 32'd4);
    if (n >= 3) begin
      chk("s3_first_gap", 32'(grants[base+1] - grants[base]), 32'd11);
      chk("s3_rate_gap", 32'(grants[base+2] - grants[base+1]), 32'd7);
    end
    n = grants.size();
    step(20);
    chk("s3_no_more_grants", 32'(grants.size()), 32'(n));
    autoAck = 1'b0; move_ack = 1'b0;
    step(2);

    // Priority, then release of the winner during settle.
    dir_req = 4'b1011;
    step(1);
    chk("s4_valid", 32'(move_valid), 32'd1);
    chk("s4_dir_down", 32'(move_dir), 32'd1);
    move_ack = 1'b1;
    step(1);
    move_ack = 1'b0; dir_req = 4'b1001;
    step(3);
    chk("s4_valid_right", 32'(move_valid), 32'd1);
    chk("s4_dir_right", 32'(move_dir), 32'd3);
    move_ack = 1'b1;
    step(1);
    move_ack = 1'b0; dir_req = '0;
    step(4);

    // Blocking flag appears while a request is outstanding.
    dir_req = 4'b0100;
    step(1);
    chk("s5_valid", 32'(move_valid), 32'd1);
    blk[2][0] = 1'b1; dir_req = '0;
    step(1);
    chk("s5_enable_left_off", 32'(enable_o[2]), 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("s5_valid_stable", 32'(move_valid), 32'd1);
      chk("s5_dir_stable", 32'(move_dir), 32'd2);
      if (i < 3) step(1);
    end
    move_ack = 1'b1;
    step(1);
    move_ack = 1'b0; blk[2] = '0;
    chk("s5_valid_drop", 32'(move_valid), 32'd0);
    step(4);

    // Reset during ISSUE.
    dir_req = 4'b0010;
    step(1);
    chk("s6_issue_valid", 32'(move_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("s6_async_valid", 32'(move_valid), 32'd0);
    chk("s6_async_enable", 32'(enable_o), 32'd0);
    chk("s6_async_dir", 32'(move_dir), 32'd0);
    dir_req = '0;
    step(1);
    rst = 1'b0;
    step(3);

    // Reset during SETTLE, button still held across release.
    dir_req = 4'b0010;
    step(1);
    move_ack = 1'b1;
    step(1);
    move_ack = 1'b0;
    rst = 1'b1;
    #1;
    chk("s6_settle_valid", 32'(move_valid), 32'd0);
    chk("s6_settle_dir", 32'(move_dir), 32'd0);
    step(1);
    rst = 1'b0;
    #1 chk("s6_deny_after_rst", 32'(deny_pulse), 32'd1);
    autoAck = 1'b1;
    step(12);
    dir_req = '0;
    step(10);
    autoAck = 1'b0; move_ack = 1'b0;
    step(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
